// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset main controller.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUCTR_ADD   = 2'b00;
   localparam logic [1:0] ALUCTR_SUB   = 2'b01;
   localparam logic [1:0] ALUCTR_RTYPE = 2'b10;
   localparam logic [1:0] ALUCTR_OR    = 2'b11;

   localparam logic [1:0] SRCB_B   = 2'b00;
   localparam logic [1:0] SRCB_4   = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] SRCB_BRA = 2'b11;

   localparam logic [1:0] PCSRC_ALU = 2'b00;
   localparam logic [1:0] PCSRC_OUT = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
      S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
   } state_t;

   // States that hold mem_req high and are guarded by the watchdog.
   function automatic logic is_req(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Unified instruction/data memory request/ready handshake.
interface mc_ctrl_if;
   logic mem_req;
   logic mem_we;
   logic iord;
   logic mem_ready;

   modport master (output mem_req, output mem_we, output iord, input mem_ready);
   modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_ctrl_wdog.sv
// Memory-wait watchdog: counts unanswered request cycles, flags expiry.
module mc_ctrl_wdog #(
   parameter int TO_W        = 8,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic waiting,
   input  logic ready,
   output logic expire
);

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || start)
         cnt <= '0;
      else if (waiting && !ready)
         cnt <= cnt + TO_W'(1);
   end

   // Expires on the MEM_TIMEOUT-th unanswered cycle; a same-cycle ready wins.
   generate
      if (MEM_TIMEOUT == 0) begin : g_off
         assign expire = 1'b0;
      end else begin : g_on
         assign expire = waiting && !ready && (cnt == TO_W'(MEM_TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller. Define MC_CTRL_ILLEGAL_TRAP_EN to halt on
// illegal opcodes instead of treating them as NOPs.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int TO_W        = 8,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  op,
   input  logic        zero,
   mc_ctrl_if.master   mem,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        ext_zero,
   output logic [1:0]  ALUctr,
   output logic        reg_we,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        bus_err,
   output logic        halted
);

   state_t state, state_nx;
   logic   req, we, iord, expire, start;

   assign mem.mem_req = req;
   assign mem.mem_we  = we;
   assign mem.iord    = iord;

   // Clear the watchdog whenever a request state is freshly entered.
   assign start = is_req(state_nx) && !(req && !mem.mem_ready);

   mc_ctrl_wdog #(.TO_W(TO_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .waiting (req),
      .ready   (mem.mem_ready),
      .expire  (expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         bus_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (expire) bus_err <= 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      req        = 1'b0;
      we         = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PCSRC_ALU;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      ext_zero   = 1'b0;
      ALUctr     = ALUCTR_ADD;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      halted     = 1'b0;
      case (state)
         S_IDLE: state_nx = S_FETCH;
         S_FETCH: begin
            req       = 1'b1;
            alu_src_b = SRCB_4;
            if (mem.mem_ready) begin
               ir_we    = 1'b1;
               pc_we    = 1'b1;
               state_nx = S_DECODE;
            end else if (expire) begin
               state_nx = S_HALT;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_BRA;
            case (op)
               OP_R:            state_nx = S_EXEC_R;
               OP_ADDIU, OP_ORI: state_nx = S_EXEC_I;
               OP_LW, OP_SW:    state_nx = S_MEM_ADDR;
               OP_BEQ:          state_nx = S_BRANCH;
               OP_J:            state_nx = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               default:         state_nx = S_HALT;
`else
               default:         state_nx = S_FETCH;
`endif
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            ALUctr    = ALUCTR_RTYPE;
            state_nx  = S_WB_R;
         end
         S_WB_R: begin
            reg_we   = 1'b1;
            reg_dst  = 1'b1;
            state_nx = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            ext_zero  = (op == OP_ORI);
            ALUctr    = (op == OP_ORI) ? ALUCTR_OR : ALUCTR_ADD;
            state_nx  = S_WB_I;
         end
         S_WB_I: begin
            reg_we   = 1'b1;
            state_nx = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_nx  = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            req  = 1'b1;
            iord = 1'b1;
            if (mem.mem_ready)  state_nx = S_MEM_WB;
            else if (expire)    state_nx = S_HALT;
         end
         S_MEM_WB: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
            state_nx   = S_FETCH;
         end
         S_MEM_WR: begin
            req  = 1'b1;
            we   = 1'b1;
            iord = 1'b1;
            if (mem.mem_ready)  state_nx = S_FETCH;
            else if (expire)    state_nx = S_HALT;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            ALUctr    = ALUCTR_SUB;
            pc_src    = PCSRC_OUT;
            pc_we     = zero;
            state_nx  = S_FETCH;
         end
         S_JUMP: begin
            pc_src   = PCSRC_JMP;
            pc_we    = 1'b1;
            state_nx = S_FETCH;
         end
         S_HALT:  halted   = 1'b1;
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction-level reference model of the
// expected per-cycle control words, directed cases then random programs.
module tb_mc_ctrl;

   localparam logic [5:0] T_R = 6'b000000, T_ADDIU = 6'b001001, T_ORI = 6'b001101,
                          T_LW = 6'b100011, T_SW = 6'b101011, T_BEQ = 6'b000100,
                          T_J = 6'b000010;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] op = '0;
   logic       zero = 1'b0;
   logic       ir_we, pc_we, alu_src_a, ext_zero, reg_we, reg_dst, mem_to_reg, bus_err, halted;
   logic [1:0] pc_src, alu_src_b, ALUctr;
   int         n_chk = 0;
   int         n_fail = 0;

   mc_ctrl_if bus ();

   mc_ctrl #(.TO_W(8), .MEM_TIMEOUT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .zero       (zero),
      .mem        (bus),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .ext_zero   (ext_zero),
      .ALUctr     (ALUctr),
      .reg_we     (reg_we),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .bus_err    (bus_err),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   wire [17:0] obs = {bus.mem_req, bus.mem_we, bus.iord, ir_we, pc_we, pc_src, alu_src_a,
                      alu_src_b, ext_zero, ALUctr, reg_we, reg_dst, mem_to_reg, bus_err, halted};

   // Control word: req we iord ir_we pc_we pc_src src_a src_b ext aluctr reg_we reg_dst m2r berr halted
   function automatic logic [17:0] w(input logic rq, mw, io, irw, pcw, input logic [1:0] pcs,
                                     input logic sa, input logic [1:0] sb, input logic ez,
                                     input logic [1:0] ac, input logic rw, rd, m2r, be, hl);
      return {rq, mw, io, irw, pcw, pcs, sa, sb, ez, ac, rw, rd, m2r, be, hl};
   endfunction

   function automatic logic rb();
      return 1'($urandom());
   endfunction

   function automatic logic legal(input logic [5:0] o);
      return o inside {T_R, T_ADDIU, T_ORI, T_LW, T_SW, T_BEQ, T_J};
   endfunction

   function automatic logic [17:0] fetch_w(input logic rdy);
      return w(1,0,0,rdy,rdy,2'b00,0,2'b01,0,2'b00,0,0,0,0,0);
   endfunction

   localparam logic [17:0] DEC_W = 18'({1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0});
   localparam logic [17:0] RD_W  = 18'({1'b1,1'b0,1'b1,15'b0});
   localparam logic [17:0] WR_W  = 18'({1'b1,1'b1,1'b1,15'b0});
   localparam logic [17:0] HALT_TO_W = 18'b11;

   // Drive this cycle's inputs, let combinational paths settle, compare, advance.
   task automatic cyc(input string tag, input logic rdy, input logic zr, input logic [17:0] exp);
      bus.mem_ready = rdy;
      zero = zr;
      #2;
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.mem_ready = rb();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("idle_after_reset", rb(), rb(), '0);
   endtask

   task automatic halt_checks(input logic berr, input int n);
      for (int i = 0; i < n; i++)
         cyc("halt_hold", rb(), rb(), berr ? HALT_TO_W : 18'b01);
   endtask

   // One instruction: fw fetch wait states, mw data wait states (4 = timeout).
   // Returns 1 when the controller ends up halted.
   task automatic run_instr(input logic [5:0] o, input logic zr, input int fw, input int mw,
                            output logic hlt);
      hlt = 1'b0;
      op = o;
      for (int i = 0; i < fw; i++) cyc("fetch_wait", 1'b0, rb(), fetch_w(1'b0));
      cyc("fetch_done", 1'b1, rb(), fetch_w(1'b1));
      cyc("decode", rb(), rb(), DEC_W);
      if (o == T_R) begin
         cyc("exec_r", rb(), rb(), w(0,0,0,0,0,2'b00,1,2'b00,0,2'b10,0,0,0,0,0));
         cyc("wb_r",   rb(), rb(), w(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,1,0,0,0));
      end else if (o == T_ADDIU || o == T_ORI) begin
         cyc("exec_i", rb(), rb(), w(0,0,0,0,0,2'b00,1,2'b10,o == T_ORI,
                                   (o == T_ORI) ? 2'b11 : 2'b00,0,0,0,0,0));
         cyc("wb_i",   rb(), rb(), w(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,0,0,0,0));
      end else if (o == T_LW || o == T_SW) begin
         cyc("mem_addr", rb(), rb(), w(0,0,0,0,0,2'b00,1,2'b10,0,2'b00,0,0,0,0,0));
         for (int i = 0; i < mw && i < 4; i++)
            cyc("mem_wait", 1'b0, rb(), (o == T_LW) ? RD_W : WR_W);
         if (mw >= 4) begin
            hlt = 1'b1;
            halt_checks(1'b1, 2);
         end else begin
            cyc("mem_done", 1'b1, rb(), (o == T_LW) ? RD_W : WR_W);
            if (o == T_LW)
               cyc("mem_wb", rb(), rb(), w(0,0,0,0,0,2'b00,0,2'b00,0,2'b00,1,0,1,0,0));
         end
      end else if (o == T_BEQ) begin
         cyc("branch", rb(), zr, w(0,0,0,0,zr,2'b01,1,2'b00,0,2'b01,0,0,0,0,0));
      end else if (o == T_J) begin
         cyc("jump", rb(), rb(), w(0,0,0,0,1,2'b10,0,2'b00,0,2'b00,0,0,0,0,0));
      end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         hlt = 1'b1;
         halt_checks(1'b0, 2);
`endif
      end
   endtask

   initial begin
      logic       h;
      logic [5:0] o;
      logic [5:0] ops [7];
      ops = '{T_R, T_ADDIU, T_ORI, T_LW, T_SW, T_BEQ, T_J};
      bus.mem_ready = 1'b0;
      #1;
      do_reset();

      run_instr(T_R,     1'b0, 0, 0, h);
      run_instr(T_LW,    1'b0, 0, 3, h);
      run_instr(T_BEQ,   1'b1, 0, 0, h);
      run_instr(T_BEQ,   1'b0, 1, 0, h);
      run_instr(T_ORI,   1'b0, 0, 0, h);
      run_instr(T_ADDIU, 1'b0, 2, 0, h);
      run_instr(T_SW,    1'b0, 3, 3, h);
      run_instr(T_J,     1'b0, 0, 0, h);
      run_instr(6'b111111, 1'b0, 0, 0, h);
      if (h) do_reset();
      run_instr(T_R,     1'b0, 0, 0, h);

      // Fetch never answered: four request cycles, then sticky error and HALT.
      op = T_R;
      for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 1'b0, rb(), fetch_w(1'b0));
      halt_checks(1'b1, 3);
      do_reset();

      // Data-phase timeout on a load.
      run_instr(T_LW, 1'b0, 0, 4, h);
      do_reset();

      // Reset while a store is outstanding abandons it.
      op = T_SW;
      cyc("fetch_done", 1'b1, rb(), fetch_w(1'b1));
      cyc("decode", rb(), rb(), DEC_W);
      cyc("mem_addr", rb(), rb(), w(0,0,0,0,0,2'b00,1,2'b10,0,2'b00,0,0,0,0,0));
      cyc("mem_wr_wait", 1'b0, rb(), WR_W);
      cyc("mem_wr_wait", 1'b0, rb(), WR_W);
      rst_n = 1'b0;
      cyc("mem_wr_at_reset", 1'b0, rb(), WR_W);
      rst_n = 1'b1;
      cyc("idle_after_abort", rb(), rb(), '0);
      run_instr(T_R, 1'b0, 3, 0, h);

      for (int n = 0; n < 80; n++) begin
         o = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 6)];
         run_instr(o, rb(), $urandom_range(0, 3),
                   ($urandom_range(0, 15) == 0) ? 4 : $urandom_range(0, 3), h);
         if (h) do_reset();
         if (!legal(o) && !h) op = o;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS-subset CPU.
- Sequences the shared datapath through fetch, decode, execute, memory and writeback steps.
- Drives the 2-bit ALUctr consumed by the ALU-op decoder, plus the datapath mux selects and write enables.
- Talks to unified instruction/data memory through a req/ready handshake with timeout protection.

Parameters:
- TO_W, 8: width of the memory-wait timeout counter.
- MEM_TIMEOUT, 255: maximum cycles mem_req may stay high without mem_ready. Must be ≤ 2^TO_W-1; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- op  in  6  instruction opcode field from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion for the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (valid only with mem_req).
- iord  out  1  address select: 0=PC, 1=ALUOut.
- ir_we  out  1  IR load.
- pc_we  out  1  PC load.
- pc_src  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target.
- alu_src_a  out  1  0=PC, 1=A reg.
- alu_src_b  out  2  00=B reg, 01=const 4, 10=extended imm, 11=sign-ext imm<<2.
- ext_zero  out  1  immediate extension: 1=zero-extend, 0=sign-extend.
- ALUctr  out  2  00=add, 01=sub, 10=R-type by func, 11=or.
- reg_we  out  1  register file write.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- bus_err  out  1  sticky memory-timeout flag.
- halted  out  1  FSM is in HALT.

Behaviour:
- Timing model:
  - State is registered.
  - Outputs are Moore decode of state, except ir_we/pc_we in FETCH, which are gated combinationally by mem_ready, and pc_we in BRANCH, which equals zero.
- Reset:
  - rst_n low at an edge: state←IDLE, timeout counter←0, bus_err←0. This applies mid-instruction too; an outstanding request is abandoned.
  - In IDLE every output is 0. IDLE→FETCH unconditionally.
- Opcodes: R=000000, addiu=001001, ori=001101, lw=100011, sw=101011, beq=000100, j=000010. Any other opcode is illegal.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ALUctr=00, pc_src=00.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_we=pc_we=1 that cycle, then →DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, ALUctr=00 (precompute branch target).
  - Transitions: R→EXEC_R; addiu/ori→EXEC_I; lw/sw→MEM_ADDR; beq→BRANCH; j→JUMP; illegal→FETCH (NOP).
- EXEC_R: alu_src_a=1, alu_src_b=00, ALUctr=10 → WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0 → FETCH.
- EXEC_I:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - ori: ext_zero=1, ALUctr=11. addiu: ext_zero=0, ALUctr=00.
  - → WB_I. The opcode is held by IR, so it is stable across states.
- WB_I: reg_we=1, reg_dst=0 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ALUctr=00 → lw: MEM_RD; sw: MEM_WR.
- MEM_RD: mem_req=1, iord=1; waits for mem_ready → MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; waits for mem_ready → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ALUctr=01, pc_src=01, pc_we=zero → FETCH.
- JUMP: pc_src=10, pc_we=1 → FETCH.
- Minimum latency with zero-wait memory (mem_ready high in the first request cycle):
  - R/addiu/ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/j: 3 cycles.
- Handshake:
  - mem_req and mem_we/iord are stable while waiting.
  - mem_ready is ignored when mem_req=0.
  - mem_ready=1 in the first req cycle completes with zero wait states.
- Timeout:
  - The counter clears on entry to any req state and increments each waiting cycle.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: bus_err←1, →HALT.
  - If mem_ready arrives in the same cycle, completion wins.
- HALT:
  - All outputs 0 except halted=1 and bus_err.
  - Exit only via reset.
- Unused outputs are 0 in every state.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE →HALT, and halted=1 (bus_err unchanged).
- Undefined: an illegal opcode is a NOP, returning to FETCH after DECODE.

Decomposition:
- Shared package/header holds:
  - opcode constants;
  - the ALUctr encodings (ALUCTR_ADD/SUB/RTYPE/OR);
  - the alu_src_b and pc_src encodings;
  - the state enumeration (4-bit: IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT).
- One sub-module, mc_ctrl_wdog: the timeout counter, with inputs start/waiting/ready and output expire.

Test Plan:
- Reset, then op=000000 with zero-wait memory → states IDLE, FETCH, DECODE, EXEC_R, WB_R; ALUctr=10 in EXEC_R; reg_we=1, reg_dst=1 in WB_R; next FETCH on cycle 5.
- lw with mem_ready delayed 3 cycles in MEM_RD → mem_req=1, iord=1 held 4 cycles; MEM_WB has mem_to_reg=1; total 8 cycles.
- beq with zero=1, then beq with zero=0 → BRANCH ALUctr=01, pc_src=01; pc_we=1 then 0.
- ori, then addiu → EXEC_I shows ext_zero=1/ALUctr=11, then ext_zero=0/ALUctr=00.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → bus_err=1 and halted=1 after the 4th wait; remains there until rst_n=0 → IDLE with all outputs 0.
- op=111111 → with MC_CTRL_ILLEGAL_TRAP_EN, HALT after DECODE; without it, FETCH after DECODE. Separately, rst_n=0 during MEM_WR → mem_req=0 next cycle, state IDLE.
